// File: rtl/requant_pipe.sv
// Five-stage streaming requantizer: LANES signed 32-bit accumulators -> packed signed OUT_BITS results.
// Each beat carries its own config down the pipe; the whole pipe advances or holds as one unit.
module requant_pipe #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned OUT_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*LANES-1:0]          in_acc,
  input  logic [4:0]                   left_shift,
  input  logic [31:0]                  multiplier,
  input  logic [4:0]                   right_shift,
  input  logic [31:0]                  out_offset,
  input  logic [31:0]                  act_min,
  input  logic [31:0]                  act_max,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_BITS*LANES-1:0]    out_data
);

  localparam logic signed [31:0] QMAX = (32'sd1 <<< (OUT_BITS - 1)) - 32'sd1;
  localparam logic signed [31:0] QMIN = -QMAX - 32'sd1;

  logic adv;
  logic s1_valid, s2_valid, s3_valid, s4_valid, s5_valid;

  logic        [31:0] s1_x [LANES];
  logic        [31:0] s1_mult;
  logic        [4:0]  s1_rsh, s2_rsh, s3_rsh;
  logic signed [31:0] s1_off, s2_off, s3_off, s4_off;
  logic signed [31:0] s1_min, s2_min, s3_min, s4_min;
  logic signed [31:0] s1_max, s2_max, s3_max, s4_max;

  logic signed [63:0] s2_p   [LANES];
  logic               s2_ovf [LANES];
  logic        [31:0] s3_h   [LANES];
  logic signed [31:0] s4_r   [LANES];

  logic        [31:0] x_next   [LANES];
  logic signed [63:0] p_next   [LANES];
  logic               ovf_next [LANES];
  logic        [31:0] h_next   [LANES];
  logic signed [31:0] r_next   [LANES];
  logic [OUT_BITS*LANES-1:0] out_next;

  assign adv       = !s5_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = s5_valid;

  always_comb begin
    logic [63:0]        sum;
    logic [63:0]        trunc;
    logic [31:0]        mask;
    logic [31:0]        rem;
    logic [31:0]        thr;
    logic signed [31:0] sh;
    logic signed [31:0] s;
    logic signed [31:0] c;
    sum      = '0;
    trunc    = '0;
    mask     = '0;
    rem      = '0;
    thr      = '0;
    sh       = '0;
    s        = '0;
    c        = '0;
    out_next = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      x_next[i]   = in_acc[32*i +: 32] << left_shift;

      p_next[i]   = $signed({{32{s1_x[i][31]}}, s1_x[i]}) * $signed({{32{s1_mult[31]}}, s1_mult});
      ovf_next[i] = (s1_x[i] == 32'h8000_0000) && (s1_mult == 32'h8000_0000);

      // Bias negative sums by 2^31-1 so the arithmetic shift truncates toward zero.
      sum   = s2_p[i] + (s2_p[i][63] ? 64'hFFFF_FFFF_C000_0001 : 64'h0000_0000_4000_0000);
      trunc = sum[63] ? sum + 64'h0000_0000_7FFF_FFFF : sum;
      h_next[i] = s2_ovf[i] ? 32'h7FFF_FFFF : trunc[62:31];

      // Shift is kept in its own signed variable so the rounding add cannot turn it logical.
      mask = (32'd1 << s3_rsh) - 32'd1;
      rem  = s3_h[i] & mask;
      thr  = (mask >> 1) + {31'd0, s3_h[i][31]};
      sh   = $signed(s3_h[i]) >>> s3_rsh;
      r_next[i] = sh + $signed({31'd0, rem > thr});

      s = s4_r[i] + s4_off;
      c = s;
      if (c < s4_min) c = s4_min;
      if (c > s4_max) c = s4_max;
      if (c < QMIN)   c = QMIN;
      if (c > QMAX)   c = QMAX;
      out_next[OUT_BITS*i +: OUT_BITS] = c[OUT_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s4_valid <= 1'b0;
      s5_valid <= 1'b0;
      s1_mult  <= '0;
      s1_rsh   <= '0;
      s2_rsh   <= '0;
      s3_rsh   <= '0;
      s1_off   <= '0;
      s2_off   <= '0;
      s3_off   <= '0;
      s4_off   <= '0;
      s1_min   <= '0;
      s2_min   <= '0;
      s3_min   <= '0;
      s4_min   <= '0;
      s1_max   <= '0;
      s2_max   <= '0;
      s3_max   <= '0;
      s4_max   <= '0;
      out_data <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_x[i]   <= '0;
        s2_p[i]   <= '0;
        s2_ovf[i] <= 1'b0;
        s3_h[i]   <= '0;
        s4_r[i]   <= '0;
      end
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s4_valid <= s3_valid;
      s5_valid <= s4_valid;

      s1_mult  <= multiplier;
      s1_rsh   <= right_shift;
      s1_off   <= out_offset;
      s1_min   <= act_min;
      s1_max   <= act_max;

      s2_rsh   <= s1_rsh;
      s2_off   <= s1_off;
      s2_min   <= s1_min;
      s2_max   <= s1_max;

      s3_rsh   <= s2_rsh;
      s3_off   <= s2_off;
      s3_min   <= s2_min;
      s3_max   <= s2_max;

      s4_off   <= s3_off;
      s4_min   <= s3_min;
      s4_max   <= s3_max;

      out_data <= out_next;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_x[i]   <= x_next[i];
        s2_p[i]   <= p_next[i];
        s2_ovf[i] <= ovf_next[i];
        s3_h[i]   <= h_next[i];
        s4_r[i]   <= r_next[i];
      end
    end
  end

endmodule

// File: tb/tb_requant_pipe.sv
// Scoreboard bench for requant_pipe: directed beats push expected packed results,
// a monitor pops and compares on every output handshake.
module tb_requant_pipe;
  localparam int unsigned LANES    = 4;
  localparam int unsigned OUT_BITS = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_acc = '0;
  logic [4:0]   left_shift = '0;
  logic [31:0]  multiplier = '0;
  logic [4:0]   right_shift = '0;
  logic [31:0]  out_offset = '0;
  logic [31:0]  act_min = '0;
  logic [31:0]  act_max = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;

  logic [31:0] sb[$];
  int passed = 0;
  int total = 0;
  int accepted = 0;

  localparam logic [31:0] LO = 32'hFFFF_FF80;
  localparam logic [31:0] HI = 32'd127;

  requant_pipe #(.LANES(LANES), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .left_shift(left_shift), .multiplier(multiplier),
    .right_shift(right_shift), .out_offset(out_offset), .act_min(act_min),
    .act_max(act_max), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] expv);
    total++;
    if (got === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, expv);
  endfunction

  // Sampled late in the low phase so it sees the same out_ready the next edge uses.
  always @(negedge clk) begin
    #3;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got %h expected no output", out_data);
      end else begin
        chk("out_data", out_data, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [127:0] acc, input logic [4:0] ls, input logic [31:0] m,
                      input logic [4:0] rs, input logic [31:0] off, input logic [31:0] mn,
                      input logic [31:0] mx, input logic [31:0] expv);
    int unsigned waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_acc = acc; left_shift = ls; multiplier = m;
    right_shift = rs; out_offset = off; act_min = mn; act_max = mx;
    #4;
    while (!in_ready && waited < 50) begin
      @(negedge clk); #4; waited++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      sb.push_back(expv);
      accepted++;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int acc0;
    int seen;
    logic [31:0] held;

    @(posedge clk); #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1 chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Overflow case with latency check.
    send({32'd0, 32'd0, 32'd0, 32'h8000_0000}, 5'd0, 32'h8000_0000, 5'd0, 32'd0, LO, HI, 32'h0000_007F);
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("latency", {31'd0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
    end

    send({4{32'd100}}, 5'd0, 32'h4000_0000, 5'd0, 32'd0, LO, HI, 32'h3232_3232);
    send({4{32'hFFFF_FFFD}}, 5'd0, 32'h7FFF_FFFF, 5'd1, 32'd0, LO, HI, 32'hFEFE_FEFE);
    send({32'd2, 32'd0, 32'hFFFF_FC18, 32'd1000}, 5'd0, 32'h4000_0000, 5'd0, 32'hFFFF_FF80, LO, HI, 32'h8180_807F);
    send({4{32'd64}}, 5'd0, 32'h7FFF_FFFF, 5'd0, 32'd0, LO, HI, 32'h4040_4040);
    send({4{32'd64}}, 5'd0, 32'h7FFF_FFFF, 5'd3, 32'd0, LO, HI, 32'h0808_0808);
    send({4{32'd1}}, 5'd4, 32'h4000_0000, 5'd0, 32'd0, LO, HI, 32'h0808_0808);
    send({32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'd100}, 5'd0, 32'h4000_0000, 5'd0, 32'd0,
         32'hFFFF_FFFB, 32'd5, 32'hFB05_FB05);
    send({4{32'd1000}}, 5'd0, 32'h4000_0000, 5'd0, 32'd0, 32'hFFFE_7960, 32'd100000, 32'h7F7F_7F7F);
    send({4{32'd100}}, 5'd0, 32'hC000_0000, 5'd0, 32'd0, LO, HI, 32'hCECE_CECE);
    idle();
    repeat (8) @(posedge clk);

    // Backpressure: 8 beats against a stalled output.
    @(negedge clk); out_ready = 1'b0;
    acc0 = accepted;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send({32'(20*k + 6), 32'(20*k + 4), 32'(20*k + 2), 32'(20*k)}, 5'd0, 32'h4000_0000,
               5'd0, 32'd0, LO, HI,
               {8'(10*k + 3), 8'(10*k + 2), 8'(10*k + 1), 8'(10*k)});
        end
        idle();
      end
      begin
        n = 0;
        while (!out_valid && n < 30) begin @(negedge clk); #3; n++; end
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        held = out_data;
        chk("bp_first", held, 32'h0302_0100);
        chk("bp_inflight", 32'(accepted - acc0), 32'd5);
        for (int c = 0; c < 6; c++) begin
          @(negedge clk); #3;
          chk("bp_hold_data", out_data, held);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        chk("bp_inflight_end", 32'(accepted - acc0), 32'd5);
        @(negedge clk); out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    chk("bp_all_accepted", 32'(accepted - acc0), 32'd8);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset mid-stream.
    for (int k = 0; k < 5; k++)
      send({4{32'd100}}, 5'd0, 32'h4000_0000, 5'd0, 32'd0, LO, HI, 32'h3232_3232);
    #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_reset_data", out_data, 32'd0);
    sb.delete();
    @(negedge clk); @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #3;
      if (out_valid) seen++;
    end
    chk("no_stale", 32'(seen), 32'd0);
    chk("ready_post_reset", {31'd0, in_ready}, 32'd1);
    send({4{32'd64}}, 5'd0, 32'h7FFF_FFFF, 5'd3, 32'd0, LO, HI, 32'h0808_0808);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    chk("final_drain", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
